// File: rtl/macro_op_sequencer_pkg.sv
// Shared types for the macro-op sequencer: scoreboard entry layout, FSM states and
// the default immediate step applied to the second micro-op.
package macro_op_sequencer_pkg;

  localparam int unsigned Xlen = 32;

  typedef struct packed {
    logic [Xlen-1:0] pc;
    logic [2:0]      trans_id;
    logic [3:0]      fu;
    logic [6:0]      op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [Xlen-1:0] result;
    logic            valid;
    logic            is_macro_instr;
    logic            is_double_rd_macro_instr;
    logic            is_last_macro_instr;
  } sb_entry_t;

  typedef enum logic [1:0] {StEmpty, StSingle, StFirst, StSecond} macro_seq_state_e;

  function automatic int unsigned default_macro_imm_step(int unsigned xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/macro_op_sequencer_if.sv
// Scoreboard issue port: entry, raw word, valid from the sequencer; ack from the scoreboard.
interface macro_op_sequencer_if;
  import macro_op_sequencer_pkg::*;

  sb_entry_t   instr;
  logic [31:0] orig_instr;
  logic        valid;
  logic        ack;

  modport master (output instr, orig_instr, valid, input ack);
  modport slave  (input instr, orig_instr, valid, output ack);

endinterface

// File: rtl/macro_op_sequencer_split.sv
// Builds the micro-op view of a held entry: untouched for plain instructions, tagged for
// the first half of a macro, retargeted to rd2 with a stepped immediate for the second half.
module macro_op_sequencer_split
  import macro_op_sequencer_pkg::*;
#(
  parameter int unsigned MacroImmStep = 4
) (
  input  sb_entry_t  entry_i,
  input  logic [4:0] rd2_i,
  input  logic       double_rd_i,
  input  logic       macro_i,
  input  logic       second_i,
  output sb_entry_t  entry_o
);

  always_comb begin
    entry_o = entry_i;
    if (macro_i) begin
      entry_o.is_macro_instr           = 1'b1;
      entry_o.is_double_rd_macro_instr = double_rd_i;
      entry_o.is_last_macro_instr      = second_i;
      if (second_i) begin
        entry_o.rd     = rd2_i;
        entry_o.result = entry_i.result + Xlen'(MacroImmStep);
      end
    end
  end

endmodule

// File: rtl/macro_op_sequencer.sv
// Registers decoded instructions toward the scoreboard and splits macro instructions into
// two back-to-back micro-ops so they receive adjacent trans_ids.
module macro_op_sequencer
  import macro_op_sequencer_pkg::*;
#(
  parameter int unsigned MacroImmStep = default_macro_imm_step(Xlen),
  parameter int unsigned CntWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  sb_entry_t               dec_instr_i,
  input  logic [31:0]             dec_orig_instr_i,
  input  logic                    dec_is_macro_i,
  input  logic                    dec_double_rd_i,
  input  logic [4:0]              dec_rd2_i,
  input  logic                    dec_valid_i,
  output logic                    dec_ready_o,
  macro_op_sequencer_if.master    sb_if,
  output logic                    busy_o,
  output logic [CntWidth-1:0]     macro_cnt_o
);

  macro_seq_state_e    state_q, state_d;
  sb_entry_t           entry_q, split_entry;
  logic [31:0]         orig_q;
  logic [4:0]          rd2_q;
  logic                dbl_q;
  logic [CntWidth-1:0] cnt_q;
  logic                accept, ack, valid;

  assign valid = (state_q != StEmpty);
  assign ack   = sb_if.ack & valid;

  always_comb begin
    state_d     = state_q;
    dec_ready_o = 1'b0;
    unique case (state_q)
      StEmpty:            dec_ready_o = 1'b1;
      StSingle, StSecond: dec_ready_o = sb_if.ack;
      StFirst:            dec_ready_o = 1'b0;
    endcase
    if (flush_i) dec_ready_o = 1'b0;
    accept = dec_valid_i & dec_ready_o;

    if (flush_i) begin
      state_d = StEmpty;
    end else if (accept) begin
      state_d = dec_is_macro_i ? StFirst : StSingle;
    end else if (ack) begin
      // Only FIRST continues on ack; SINGLE and SECOND drain to EMPTY.
      state_d = (state_q == StFirst) ? StSecond : StEmpty;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      entry_q <= '0;
      orig_q  <= '0;
      rd2_q   <= '0;
      dbl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        entry_q <= dec_instr_i;
        orig_q  <= dec_orig_instr_i;
        if (dec_is_macro_i) begin
          rd2_q <= dec_rd2_i;
          dbl_q <= dec_double_rd_i;
          if (cnt_q != '1) cnt_q <= cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  macro_op_sequencer_split #(
    .MacroImmStep (MacroImmStep)
  ) u_split (
    .entry_i     (entry_q),
    .rd2_i       (rd2_q),
    .double_rd_i (dbl_q),
    .macro_i     (busy_o),
    .second_i    (state_q == StSecond),
    .entry_o     (split_entry)
  );

  assign busy_o           = (state_q == StFirst) || (state_q == StSecond);
  assign sb_if.valid      = valid;
  assign sb_if.instr      = split_entry;
  assign sb_if.orig_instr = orig_q;
  assign macro_cnt_o      = cnt_q;

endmodule

// File: tb/tb_macro_op_sequencer.sv
// Randomised and directed bench for macro_op_sequencer against a queue-based model of
// the micro-ops still owed to the scoreboard.
module tb_macro_op_sequencer;
  import macro_op_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush, dec_valid, dec_is_macro, dec_double_rd;
  sb_entry_t   dec_instr;
  logic [31:0] dec_orig;
  logic [4:0]  dec_rd2;
  logic        dec_ready, busy, ready_s, busy_s;
  logic [15:0] cnt;
  logic [2:0]  cnt_s;

  macro_op_sequencer_if sb_if ();
  macro_op_sequencer_if sb_if_s ();

  always #5 clk = ~clk;

  macro_op_sequencer dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .dec_instr_i      (dec_instr),
    .dec_orig_instr_i (dec_orig),
    .dec_is_macro_i   (dec_is_macro),
    .dec_double_rd_i  (dec_double_rd),
    .dec_rd2_i        (dec_rd2),
    .dec_valid_i      (dec_valid),
    .dec_ready_o      (dec_ready),
    .sb_if            (sb_if),
    .busy_o           (busy),
    .macro_cnt_o      (cnt)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  macro_op_sequencer #(
    .CntWidth (3)
  ) dut_sat (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .dec_instr_i      (dec_instr),
    .dec_orig_instr_i (dec_orig),
    .dec_is_macro_i   (dec_is_macro),
    .dec_double_rd_i  (dec_double_rd),
    .dec_rd2_i        (dec_rd2),
    .dec_valid_i      (dec_valid),
    .dec_ready_o      (ready_s),
    .sb_if            (sb_if_s),
    .busy_o           (busy_s),
    .macro_cnt_o      (cnt_s)
  );

  typedef struct {
    sb_entry_t   e;
    logic [31:0] orig;
    bit          mac;
  } exp_t;

  exp_t        q[$];
  int unsigned n_macro;
  int unsigned n_checks = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic sb_entry_t mask_tid(sb_entry_t x);
    x.trans_id = '0;
    return x;
  endfunction

  function automatic sb_entry_t rand_entry();
    sb_entry_t x;
    x.pc                       = $urandom;
    x.trans_id                 = 3'($urandom);
    x.fu                       = 4'($urandom);
    x.op                       = 7'($urandom);
    x.rs1                      = 5'($urandom);
    x.rs2                      = 5'($urandom);
    x.rd                       = 5'($urandom);
    x.result                   = $urandom;
    x.valid                    = 1'($urandom);
    x.is_macro_instr           = 1'($urandom);
    x.is_double_rd_macro_instr = 1'($urandom);
    x.is_last_macro_instr      = 1'($urandom);
    return x;
  endfunction

  function automatic int unsigned sat(int unsigned n, int unsigned mx);
    return (n > mx) ? mx : n;
  endfunction

  // One clock: drive inputs, compare at negedge, advance model, land at posedge+1.
  task automatic step(input bit v, input bit mac, input bit dbl, input logic [4:0] rd2,
                      input sb_entry_t e, input logic [31:0] orig, input bit ack, input bit fl);
    bit   exp_ready;
    exp_t a, b;
    dec_valid = v; dec_is_macro = mac; dec_double_rd = dbl; dec_rd2 = rd2;
    dec_instr = e; dec_orig = orig; sb_if.ack = ack; sb_if_s.ack = ack; flush = fl;
    @(negedge clk);
    exp_ready = !fl && (q.size() == 0 || (q.size() == 1 && ack));
    check("sb_valid", 128'(sb_if.valid), 128'(q.size() != 0));
    if (q.size() != 0) begin
      check("sb_instr", 128'(mask_tid(sb_if.instr)), 128'(mask_tid(q[0].e)));
      check("sb_orig", 128'(sb_if.orig_instr), 128'(q[0].orig));
    end
    check("dec_ready", 128'(dec_ready), 128'(exp_ready));
    check("busy", 128'(busy), 128'(q.size() != 0 && q[0].mac));
    check("macro_cnt", 128'(cnt), 128'(sat(n_macro, 65535)));
    check("sat_ready", 128'(ready_s), 128'(exp_ready));
    check("sat_cnt", 128'(cnt_s), 128'(sat(n_macro, 7)));
    if (fl) begin
      q.delete();
    end else begin
      if (ack && q.size() != 0) void'(q.pop_front());
      if (v && exp_ready) begin
        if (mac) begin
          a.e = e; a.orig = orig; a.mac = 1'b1;
          a.e.is_macro_instr = 1'b1; a.e.is_double_rd_macro_instr = dbl;
          a.e.is_last_macro_instr = 1'b0;
          b = a;
          b.e.rd = rd2; b.e.result = e.result + 32'd4; b.e.is_last_macro_instr = 1'b1;
          q.push_back(a);
          q.push_back(b);
          n_macro++;
        end else begin
          a.e = e; a.orig = orig; a.mac = 1'b0;
          q.push_back(a);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    flush = 1'b0; dec_valid = 1'b0; sb_if.ack = 1'b0; sb_if_s.ack = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", 128'(sb_if.valid), 128'(0));
    check("rst_instr", 128'(sb_if.instr), 128'(0));
    check("rst_orig", 128'(sb_if.orig_instr), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_cnt", 128'(cnt), 128'(0));
    q.delete();
    n_macro = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    sb_entry_t e;
    dec_instr = '0; dec_orig = '0; dec_rd2 = '0; dec_is_macro = 1'b0; dec_double_rd = 1'b0;
    apply_reset();

    // Plain instruction with rd=5, continuous ack.
    e = rand_entry(); e.rd = 5'd5;
    step(1, 0, 0, 5'd0, e, 32'h1234_5678, 1, 0);
    check("t1_valid", 128'(sb_if.valid), 128'(1));
    check("t1_rd", 128'(sb_if.instr.rd), 128'(5));
    step(0, 0, 0, 5'd0, rand_entry(), 32'h0, 1, 0);

    // Macro rd=5 / rd2=6, result 0x100, double-rd, continuous ack.
    e = rand_entry(); e.rd = 5'd5; e.result = 32'h100;
    step(1, 1, 1, 5'd6, e, 32'hCAFE_0001, 1, 0);
    check("t2_first_rd", 128'(sb_if.instr.rd), 128'(5));
    check("t2_first_res", 128'(sb_if.instr.result), 128'(32'h100));
    check("t2_first_last", 128'(sb_if.instr.is_last_macro_instr), 128'(0));
    check("t2_first_dbl", 128'(sb_if.instr.is_double_rd_macro_instr), 128'(1));
    step(1, 0, 0, 5'd0, rand_entry(), 32'h0, 1, 0);
    step(0, 0, 0, 5'd0, rand_entry(), 32'h0, 1, 0);
    step(0, 0, 0, 5'd0, rand_entry(), 32'h0, 1, 0);
    check("t2_cnt", 128'(cnt), 128'(1));

    // Macro with ack held low for three cycles.
    e = rand_entry(); e.rd = 5'd9;
    step(1, 1, 0, 5'd10, e, 32'hBEEF_0002, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 5'd0, rand_entry(), 32'h0, 0, 0);
    check("t3_held_rd", 128'(sb_if.instr.rd), 128'(9));
    step(0, 0, 0, 5'd0, rand_entry(), 32'h0, 1, 0);
    check("t3_second_rd", 128'(sb_if.instr.rd), 128'(10));
    step(0, 0, 0, 5'd0, rand_entry(), 32'h0, 1, 0);

    // Flush while the second micro-op is pending.
    e = rand_entry();
    step(1, 1, 1, 5'd7, e, 32'h0000_0003, 1, 0);
    step(0, 0, 0, 5'd0, rand_entry(), 32'h0, 1, 0);
    step(1, 0, 0, 5'd0, rand_entry(), 32'h0, 1, 1);
    check("t4_valid", 128'(sb_if.valid), 128'(0));
    check("t4_cnt", 128'(cnt), 128'(3));
    step(0, 0, 0, 5'd0, rand_entry(), 32'h0, 1, 0);

    // Immediate wraps modulo 2^32 on the second micro-op.
    e = rand_entry(); e.result = 32'hFFFF_FFFE;
    step(1, 1, 0, 5'd1, e, 32'h0000_0004, 1, 0);
    step(0, 0, 0, 5'd0, rand_entry(), 32'h0, 1, 0);
    check("t5_wrap", 128'(sb_if.instr.result), 128'(32'h2));
    step(0, 0, 0, 5'd0, rand_entry(), 32'h0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, 1'($urandom), 5'($urandom),
           rand_entry(), $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);
    end
    check("t6_sat", 128'(cnt_s), 128'(7));

    // Reset during a split clears everything at once.
    step(0, 0, 0, 5'd0, rand_entry(), 32'h0, 1, 1);
    step(1, 1, 1, 5'd3, rand_entry(), 32'h0000_0005, 0, 0);
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 5'd0, rand_entry(), $urandom, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
